// File: rtl/leds_pkg.sv
// Shared types and constants for the LED pattern engine and its users.
package leds_pkg;

  typedef enum logic [1:0] {
    STATIC = 2'd0,
    BLINK  = 2'd1,
    CHASE  = 2'd2,
    BOUNCE = 2'd3
  } mode_e;

  // Wide enough for any practical PWM width; users slice off what they need.
  localparam logic [15:0] DEFAULT_BRIGHTNESS = '1;

endpackage

// File: rtl/leds_pattern_if.sv
// Config and LED-drive bundle between the control logic and the pattern engine.
interface leds_pattern_if #(
  parameter int N_LEDS   = 4,
  parameter int PWM_BITS = 4
) ();
  import leds_pkg::*;

  logic                cfg_we;
  mode_e               mode;
  logic [N_LEDS-1:0]   pattern;
  logic [PWM_BITS-1:0] brightness;
  logic [N_LEDS-1:0]   led;
  logic                tick;

  modport master (output cfg_we, mode, pattern, brightness, input led, tick);
  modport slave  (input cfg_we, mode, pattern, brightness, output led, tick);

endinterface

// File: rtl/leds_prescaler.sv
// Free-running tick prescaler: pulses tick while the count sits at PRESCALE-1.
module leds_prescaler #(
  parameter int PRESCALE = 3_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/leds_pattern.sv
// LED pattern engine: animates a loaded pattern per prescaled tick and dims it with PWM.
module leds_pattern
  import leds_pkg::*;
#(
  parameter int N_LEDS   = 4,
  parameter int PRESCALE = 3_000_000,
  parameter int PWM_BITS = 4
) (
  input logic            clk,
  input logic            rst_n,
  leds_pattern_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] FULL_ON = DEFAULT_BRIGHTNESS[PWM_BITS-1:0];

  mode_e               mode_q, mode_d;
  logic [N_LEDS-1:0]   pat_q, pat_d;
  logic                phase_q, phase_d;
  logic                dir_q, dir_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic                tick_q, tick_d;
  logic                step;
  logic [N_LEDS-1:0]   disp;
  logic                pwm_on;

  leds_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.cfg_we),
    .tick (step)
  );

  // A config write wins over a coincident step, which is simply lost.
  always_comb begin
    mode_d  = mode_q;
    pat_d   = pat_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    if (bus.cfg_we) begin
      mode_d  = bus.mode;
      pat_d   = bus.pattern;
      phase_d = 1'b1;
      dir_d   = 1'b0;
    end else if (step) begin
      case (mode_q)
        STATIC: pat_d = pat_q;
        BLINK:  phase_d = ~phase_q;
        CHASE:  pat_d = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
        BOUNCE: begin
          if (!dir_q) begin
            if (pat_q[N_LEDS-1]) begin
              dir_d = 1'b1;
              pat_d = pat_q >> 1;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = 1'b0;
              pat_d = pat_q << 1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        default: pat_d = pat_q;
      endcase
    end
  end

  always_comb begin
    disp   = ((mode_q == BLINK) && !phase_q) ? '0 : pat_q;
    pwm_on = (pwm_q < bus.brightness) || (bus.brightness == FULL_ON);
    led_d  = disp & {N_LEDS{pwm_on}};
    tick_d = step & ~bus.cfg_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= STATIC;
      pat_q   <= '0;
      phase_q <= 1'b0;
      dir_q   <= 1'b0;
      pwm_q   <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      pwm_q   <= pwm_q + PWM_BITS'(1);
      led_q   <= led_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_leds_pattern.sv
// Bench for leds_pattern: per-cycle reference model plus directed sequence checks.
module tb_leds_pattern;
  import leds_pkg::*;

  localparam int NL = 4;
  localparam int P  = 4;
  localparam int PB = 2;
  localparam int PATMOD = 1 << NL;
  localparam int PWMMOD = 1 << PB;
  localparam int BMAX   = PWMMOD - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] expSeq [8];

  always #5 clk = ~clk;

  leds_pattern_if #(.N_LEDS(NL), .PWM_BITS(PB)) bus ();

  leds_pattern #(.N_LEDS(NL), .PRESCALE(P), .PWM_BITS(PB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model: animation state as plain integers, outputs predicted one edge ahead.
  int mMode = 0, mPat = 0, mPhase = 0, mDir = 0, mPre = 0, mPwm = 0;
  int expLed = 0, expTick = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mMode = 0; mPat = 0; mPhase = 0; mDir = 0; mPre = 0; mPwm = 0;
      expLed = 0; expTick = 0;
    end else begin
      int shown;
      int b;
      b = int'(bus.brightness);
      shown = (mMode == 1 && mPhase == 0) ? 0 : mPat;
      expLed = ((b == BMAX) || (mPwm < b)) ? shown : 0;
      expTick = (mPre == P - 1 && !bus.cfg_we) ? 1 : 0;
      if (bus.cfg_we) begin
        mMode = int'(bus.mode); mPat = int'(bus.pattern);
        mPhase = 1; mDir = 0; mPre = 0;
      end else begin
        if (mPre == P - 1) begin
          if (mMode == 1) mPhase = 1 - mPhase;
          else if (mMode == 2) mPat = (mPat * 2) % PATMOD + mPat / (PATMOD / 2);
          else if (mMode == 3) begin
            if (mDir == 0) begin
              if (mPat >= PATMOD / 2) begin mDir = 1; mPat = mPat / 2; end
              else mPat = (mPat * 2) % PATMOD;
            end else begin
              if (mPat % 2 == 1) begin mDir = 0; mPat = (mPat * 2) % PATMOD; end
              else mPat = mPat / 2;
            end
          end
        end
        mPre = (mPre + 1) % P;
      end
      mPwm = (mPwm + 1) % PWMMOD;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("modelLed", int'(bus.led), expLed);
    checkOutput("modelTick", int'(bus.tick), expTick);
  end

  task automatic applyStimulus(input logic we, input mode_e m, input logic [3:0] p, input logic [1:0] b);
    @(negedge clk);
    bus.cfg_we = we; bus.mode = m; bus.pattern = p; bus.brightness = b;
  endtask

  task automatic loadConfig(input mode_e m, input logic [3:0] p);
    applyStimulus(1'b1, m, p, bus.brightness);
    applyStimulus(1'b0, mode_e'($urandom_range(0, 3)), 4'($urandom), bus.brightness);
  endtask

  task automatic waitTick(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.tick && cycles < 3 * P);
    if (!bus.tick) checkOutput({name, "Timeout"}, 0, 1);
  endtask

  task automatic checkSequence(input string name, input mode_e m, input logic [3:0] p, input int n);
    int c;
    loadConfig(m, p);
    @(negedge clk);
    checkOutput(name, int'(bus.led), int'(expSeq[0]));
    for (int i = 1; i < n; i++) begin
      waitTick(name, c);
      @(negedge clk);
      checkOutput(name, int'(bus.led), int'(expSeq[i]));
    end
  endtask

  task automatic checkPwm(input logic [1:0] b, input int expOn);
    int on;
    on = 0;
    bus.brightness = b;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.led == 4'hF) on++;
    end
    checkOutput("pwmOnCount", on, expOn);
  endtask

  initial begin
    int c;
    bus.cfg_we = 1'b0;
    bus.mode = mode_e'($urandom_range(0, 3));
    bus.pattern = 4'($urandom);
    bus.brightness = 2'($urandom);
    repeat (4) applyStimulus(1'b0, mode_e'($urandom_range(0, 3)), 4'($urandom), 2'($urandom));
    @(negedge clk);
    rst_n = 1'b1;
    bus.brightness = 2'd3;
    repeat (2) begin
      @(negedge clk);
      checkOutput("resetLed", int'(bus.led), 0);
      checkOutput("resetTick", int'(bus.tick), 0);
    end

    expSeq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
    checkSequence("chase", CHASE, 4'b0001, 5);
    waitTick("chasePeriod", c);
    waitTick("chasePeriod", c);
    checkOutput("tickPeriod", c, P);

    expSeq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    checkSequence("bounce", BOUNCE, 4'b0001, 8);

    expSeq = '{4'hA, 4'h0, 4'hA, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0};
    checkSequence("blink", BLINK, 4'b1010, 5);

    loadConfig(STATIC, 4'b1111);
    checkPwm(2'd1, 2);
    checkPwm(2'd0, 0);
    checkPwm(2'd3, 8);

    // Collision: tick output seen in cycle x means the next internal tick lands in x+3.
    loadConfig(CHASE, 4'b0001);
    waitTick("collisionSync", c);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, CHASE, 4'b0011, 2'd3);
    applyStimulus(1'b0, CHASE, 4'b0101, 2'd3);
    checkOutput("collisionNoTick", int'(bus.tick), 0);
    @(negedge clk);
    checkOutput("collisionLoad", int'(bus.led), 4'b0011);
    waitTick("collisionTick", c);
    checkOutput("collisionDelay", c + 2, P + 1);
    checkOutput("collisionHold", int'(bus.led), 4'b0011);

    for (int i = 0; i < 250; i++) begin
      logic [3:0] p;
      p = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      applyStimulus($urandom_range(0, 6) == 0, mode_e'($urandom_range(0, 3)), p, 2'($urandom));
      if (i == 120) begin
        #2 rst_n = 1'b0;
        #1 checkOutput("asyncResetLed", int'(bus.led), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    bus.cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/leds_pattern.md
# leds_pattern

Parametrised LED pattern driver for the board's user LEDs, replacing fixed tie-off LED assignments with a clocked engine. Holds a programmable pattern and animates it at a prescaled tick rate in one of four modes (static, blink, chase, bounce). Output brightness is scaled by a PWM dimmer. It sits at the top level between the board clock/reset pins and the LED pins, and is configured by whatever control logic drives its config port.

## Interface
- `N_LEDS`, default 4: number of LED outputs; must be ≥ 2.
- `PRESCALE`, default 3_000_000: clock cycles per animation tick (0.25 s at 12 MHz); must be ≥ 2.
- `PWM_BITS`, default 4: width of the brightness control and PWM counter.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `cfg_we`, input, 1: one-cycle strobe that loads `mode` and `pattern`.
- `mode`, input, 2: animation mode (`leds_pkg::mode_e`); sampled only when `cfg_we` = 1.
- `pattern`, input, N_LEDS: seed pattern; sampled only when `cfg_we` = 1.
- `brightness`, input, PWM_BITS: duty control; sampled every cycle.
- `led`, output, N_LEDS: registered LED drive, 1 = on.
- `tick`, output, 1: registered one-cycle pulse, once per animation step.

## Operation
- Modes are STATIC=0, BLINK=1, CHASE=2 and BOUNCE=3.
- **State registers:**
  - `mode_q`
  - `pat_q[N_LEDS-1:0]`
  - `phase` (blink)
  - `dir` (0 = left/up, 1 = right/down)
  - prescaler count
  - PWM count
- **Reset values:**
  - `led` = 0 and `tick` = 0.
  - `mode_q` = STATIC and `pat_q` = 0.
  - `phase` = 0 and `dir` = 0.
  - Both counters = 0.
- **Prescaler:** counts 0..PRESCALE-1 and wraps to 0. An internal tick occurs in the cycle where the count = PRESCALE-1.
- **Config load** (`cfg_we` = 1):
  - `mode_q` ← `mode`, `pat_q` ← `pattern`.
  - `phase` ← 1, `dir` ← 0.
  - Prescaler count ← 0.
  - Config has priority over a coincident tick; that tick is dropped.
- **On tick** (no `cfg_we`):
  - STATIC: no change.
  - BLINK: `phase` toggles.
  - CHASE: rotate left by one; bit N_LEDS-1 goes to bit 0.
  - BOUNCE, `dir` = 0: if `pat_q[N_LEDS-1]`, set `dir` ← 1 and shift right by 1; else shift left by 1 (zero fill).
  - BOUNCE, `dir` = 1: if `pat_q[0]`, set `dir` ← 0 and shift left by 1; else shift right by 1 (zero fill).
  - An all-zero pattern stays all-zero in every mode.
- **Display vector:**
  - BLINK: `phase` ? `pat_q` : 0.
  - All other modes: `pat_q`.
- **PWM:**
  - A free-running PWM_BITS counter increments every cycle.
  - `pwm_on` = (`pwm_cnt` < `brightness`) OR (`brightness` = all ones), so maximum brightness is continuously on.
  - `brightness` = 0 means LEDs are always off.
- `led` ← display & {N_LEDS{`pwm_on`}}, registered.

## Timing
- `cfg_we` in cycle t gives new state in t+1 and is visible on `led` at t+2.
- The first tick after a config load is seen internally at t+PRESCALE; `tick` pulses at t+PRESCALE+1.
- `tick` is high for exactly 1 cycle, with period PRESCALE cycles while no config is written.
- `led` lags any state or PWM change by 1 cycle.
- PWM period is 2^PWM_BITS cycles. Duty = `brightness` / 2^PWM_BITS, except at all ones, where it is 100 %.
- A `mode` or `pattern` change without `cfg_we` has no effect.
- `rst_n` asserted mid-animation clears all state immediately (asynchronously). The first prescaler count happens on the first edge after deassertion.

## Structure
- **`leds_pkg`** holds:
  - `typedef enum logic [1:0] mode_e`, with STATIC, BLINK, CHASE, BOUNCE.
  - A default-brightness constant, all ones.
- **`leds_prescaler`** is the natural sub-module.
  - Parameter: `PRESCALE`.
  - Ports: `clk`, `rst_n`, `clr`, `tick`.
  - It is reused by later timed board examples.
- `leds_pattern` instantiates the prescaler and contains the pattern/direction FSM, the PWM counter and the output register.

## Test plan
Bench parameters: N_LEDS=4, PRESCALE=4, PWM_BITS=2.
- **Reset:** hold `rst_n`=0 with random inputs, then release. Expect `led`=0000 and `tick`=0 until the first config load.
- **CHASE:** load pattern 0001, brightness 3. Expect `led` to step 0001→0010→0100→1000→0001, one step per `tick`, period 4 cycles.
- **BOUNCE:** load 0001, brightness 3. Expect the sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- **BLINK:** load 1010, brightness 3. Expect `led` to alternate 1010/0000 every 4 cycles, starting at 1010.
- **PWM:** STATIC 1111. Brightness 1 gives `led`=1111 in 1 of every 4 cycles; brightness 0 gives always 0000; brightness 3 gives always 1111.
- **Collision:** assert `cfg_we` in the same cycle as the internal tick. Expect no shift, the new pattern loaded, and the next `tick` exactly PRESCALE cycles later.
